// File: rtl/multi_timer_pkg.sv
// rtl/multi_timer_pkg.sv - shared channel state encoding and prescaler width helper
package multi_timer_pkg;

    typedef enum logic [1:0] {
        CH_IDLE   = 2'd0,
        CH_RUN    = 2'd1,
        CH_PAUSED = 2'd2
    } ch_state_e;

    // Smallest width able to hold 0..hz-1 (ceil log2, minimum 1).
    function automatic int presc_width(input int hz);
        int w;
        w = 1;
        while ((64'd1 << w) < 64'(hz)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one countdown channel: state, seconds count, private prescaler, expiry strobe
module timer_channel
    import multi_timer_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int VALUE_W = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               pause,
    input  logic [VALUE_W-1:0] value,
    output logic               expired,
    output logic               expired_pulse,
    output logic               running,
    output logic [VALUE_W-1:0] count
);

    localparam int            PW        = presc_width(CLK_HZ);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

    ch_state_e          state_q, state_d;
    logic [VALUE_W-1:0] count_q, count_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic               pulse_q, pulse_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= CH_IDLE;
            count_q <= '0;
            presc_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            presc_q <= presc_d;
            pulse_q <= pulse_d;
        end
    end

    // start overrides everything, including a tick that would expire this cycle
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        presc_d = presc_q;
        pulse_d = 1'b0;
        if (start) begin
            presc_d = '0;
            if (value != '0) begin
                state_d = CH_RUN;
                count_d = value;
            end else begin
                state_d = CH_IDLE;
                count_d = '0;
                pulse_d = 1'b1;
            end
        end else begin
            case (state_q)
                CH_RUN, CH_PAUSED: begin
                    if (pause) begin
                        state_d = CH_PAUSED;
                    end else begin
                        // the resume cycle already counts, so paused cycles are excluded exactly
                        state_d = CH_RUN;
                        if (presc_q == PRESC_MAX) begin
                            presc_d = '0;
                            count_d = count_q - VALUE_W'(1);
                            if (count_q == VALUE_W'(1)) begin
                                state_d = CH_IDLE;
                                pulse_d = 1'b1;
                            end
                        end else begin
                            presc_d = presc_q + PW'(1);
                        end
                    end
                end
                default: begin
                    state_d = CH_IDLE;
                    count_d = '0;
                    presc_d = '0;
                end
            endcase
        end
    end

    assign expired       = (state_q == CH_IDLE);
    assign running       = (state_q == CH_RUN);
    assign expired_pulse = pulse_q;
    assign count         = count_q;

endmodule

// File: rtl/multi_timer.sv
// rtl/multi_timer.sv - N independent seconds countdown channels with shared 1 Hz strobe and blink
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int N_CH    = 2,
    parameter int VALUE_W = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_CH-1:0]         start,
    input  logic [N_CH-1:0]         pause,
    input  logic [N_CH*VALUE_W-1:0] value,
    output logic [N_CH-1:0]         expired,
    output logic [N_CH-1:0]         expired_pulse,
    output logic                    one_hz_enable,
    output logic                    blink,
    output logic [N_CH*VALUE_W-1:0] value_display
);

    localparam int            PW         = presc_width(CLK_HZ);
    localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_HZ / 2 - 1);

    logic [PW-1:0]   presc_q;
    logic [N_CH-1:0] ch_running;
    logic            any_running;

    genvar i;
    generate
        for (i = 0; i < N_CH; i++) begin : g_ch
            timer_channel #(
                .CLK_HZ (CLK_HZ),
                .VALUE_W(VALUE_W)
            ) u_ch (
                .clock        (clock),
                .reset        (reset),
                .start        (start[i]),
                .pause        (pause[i]),
                .value        (value[i*VALUE_W +: VALUE_W]),
                .expired      (expired[i]),
                .expired_pulse(expired_pulse[i]),
                .running      (ch_running[i]),
                .count        (value_display[i*VALUE_W +: VALUE_W])
            );
        end
    endgenerate

    assign any_running = |ch_running;

    // free-running, unaffected by channel activity
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
        end else if (presc_q == PRESC_MAX) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    assign one_hz_enable = (presc_q == PRESC_MAX);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            blink <= 1'b0;
        end else if (!any_running) begin
            blink <= 1'b0;
        end else if (presc_q == PRESC_HALF || presc_q == PRESC_MAX) begin
            blink <= ~blink;
        end
    end

endmodule

// File: tb/tb_multi_timer.sv
// tb/tb_multi_timer.sv - randomized self-checking bench for multi_timer against a remaining-cycles model
module tb_multi_timer;

    localparam int CLK_HZ  = 10;
    localparam int N_CH    = 2;
    localparam int VALUE_W = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] start = '0;
    logic [1:0] pause = '0;
    logic [7:0] value = '0;
    logic [1:0] expired, expired_pulse;
    logic       one_hz_enable, blink;
    logic [7:0] value_display;
    logic [13:0] got;

    int errors = 0;
    int checks = 0;

    // model: remaining unpaused cycles per channel, plus seconds phase since reset
    int rem[2];
    bit act[2];
    bit psd[2];
    bit m_pulse[2];
    int gcnt;
    bit m_blink;

    multi_timer #(
        .CLK_HZ (CLK_HZ),
        .N_CH   (N_CH),
        .VALUE_W(VALUE_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .pause        (pause),
        .value        (value),
        .expired      (expired),
        .expired_pulse(expired_pulse),
        .one_hz_enable(one_hz_enable),
        .blink        (blink),
        .value_display(value_display)
    );

    always #5 clock = ~clock;

    assign got = {expired, expired_pulse, value_display, blink, one_hz_enable};

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            rem[i] = 0; act[i] = 0; psd[i] = 0; m_pulse[i] = 0;
        end
        gcnt = 0;
        m_blink = 0;
    endtask

    task automatic model_edge();
        bit any_run;
        int v;
        if (!reset) begin
            model_reset();
            return;
        end
        any_run = 0;
        for (int i = 0; i < 2; i++) if (act[i] && !psd[i]) any_run = 1;
        if (!any_run) m_blink = 0;
        else if (gcnt == CLK_HZ/2 - 1 || gcnt == CLK_HZ - 1) m_blink = !m_blink;
        gcnt = (gcnt + 1) % CLK_HZ;
        for (int i = 0; i < 2; i++) begin
            m_pulse[i] = 0;
            v = int'(value[i*VALUE_W +: VALUE_W]);
            if (start[i]) begin
                psd[i] = 0;
                if (v > 0) begin act[i] = 1; rem[i] = v * CLK_HZ; end
                else begin act[i] = 0; rem[i] = 0; m_pulse[i] = 1; end
            end else if (act[i]) begin
                if (pause[i]) psd[i] = 1;
                else begin
                    psd[i] = 0;
                    rem[i] = rem[i] - 1;
                    if (rem[i] == 0) begin act[i] = 0; m_pulse[i] = 1; end
                end
            end
        end
    endtask

    function automatic logic [13:0] exp_vec();
        logic [1:0] e, p;
        logic [7:0] d;
        for (int i = 0; i < 2; i++) begin
            e[i] = !act[i];
            p[i] = m_pulse[i];
            d[i*4 +: 4] = act[i] ? 4'((rem[i] + CLK_HZ - 1) / CLK_HZ) : 4'd0;
        end
        return {e, p, d, m_blink, (gcnt == CLK_HZ - 1)};
    endfunction

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (got !== 14'h3000) begin
            errors++; $display("FAIL reset_values got=%h exp=%h", got, 14'h3000);
        end
        tick();
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (got !== exp_vec()) begin
            errors++; $display("FAIL reset_release got=%h exp=%h", got, exp_vec());
        end
    endtask

    task automatic test_countdown();
        value[3:0] = 4'd3; start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        checks++;
        if (value_display[3:0] !== 4'd3 || expired[0] !== 1'b0) begin
            errors++; $display("FAIL countdown_load disp=%0d exp=3 expired=%b exp=0", value_display[3:0], expired[0]);
        end
        for (int k = 1; k <= 35; k++) begin
            tick();
            checks++;
            if (got !== exp_vec()) begin
                errors++; $display("FAIL countdown_model k=%0d got=%h exp=%h", k, got, exp_vec());
            end
            checks++;
            if (expired_pulse[0] !== (k == 30)) begin
                errors++; $display("FAIL countdown_pulse k=%0d got=%b exp=%b", k, expired_pulse[0], (k == 30));
            end
            if (k == 10 || k == 20 || k == 30) begin
                checks++;
                if (value_display[3:0] !== 4'(3 - k/10)) begin
                    errors++; $display("FAIL countdown_disp k=%0d got=%0d exp=%0d", k, value_display[3:0], 3 - k/10);
                end
            end
        end
        checks++;
        if (expired[0] !== 1'b1) begin
            errors++; $display("FAIL countdown_expired got=%b exp=1", expired[0]);
        end
    endtask

    task automatic test_pause();
        int first;
        first = -1;
        value[3:0] = 4'd5; start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        for (int k = 1; k <= 65; k++) begin
            pause[0] = (k >= 13 && k <= 19);
            tick();
            checks++;
            if (got !== exp_vec()) begin
                errors++; $display("FAIL pause_model k=%0d got=%h exp=%h", k, got, exp_vec());
            end
            if (expired_pulse[0] && first < 0) first = k;
        end
        pause[0] = 1'b0;
        checks++;
        if (first !== 57) begin
            errors++; $display("FAIL pause_expiry_cycle got=%0d exp=57", first);
        end
    endtask

    task automatic test_zero_start();
        value[7:4] = 4'd0; start[1] = 1'b1;
        tick();
        start[1] = 1'b0;
        checks++;
        if (expired[1] !== 1'b1 || expired_pulse[1] !== 1'b1) begin
            errors++; $display("FAIL zero_start expired=%b pulse=%b exp=1,1", expired[1], expired_pulse[1]);
        end
        tick();
        checks++;
        if (expired[1] !== 1'b1 || expired_pulse[1] !== 1'b0) begin
            errors++; $display("FAIL zero_start_after expired=%b pulse=%b exp=1,0", expired[1], expired_pulse[1]);
        end
    endtask

    task automatic test_restart();
        int first;
        first = -1;
        value[3:0] = 4'd1; start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        for (int k = 1; k <= 9; k++) tick();
        value[3:0] = 4'd9; start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        checks++;
        if (expired_pulse[0] !== 1'b0 || value_display[3:0] !== 4'd9) begin
            errors++; $display("FAIL restart_load pulse=%b exp=0 disp=%0d exp=9", expired_pulse[0], value_display[3:0]);
        end
        for (int j = 1; j <= 95; j++) begin
            tick();
            checks++;
            if (got !== exp_vec()) begin
                errors++; $display("FAIL restart_model j=%0d got=%h exp=%h", j, got, exp_vec());
            end
            if (expired_pulse[0] && first < 0) first = j;
        end
        checks++;
        if (first !== 90) begin
            errors++; $display("FAIL restart_expiry_cycle got=%0d exp=90", first);
        end
    endtask

    task automatic test_reset_mid();
        value[3:0] = 4'd4; start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        for (int k = 1; k <= 15; k++) tick();
        #2 reset = 1'b0;
        #1;
        model_reset();
        checks++;
        if (got !== 14'h3000) begin
            errors++; $display("FAIL reset_mid_async got=%h exp=%h", got, 14'h3000);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (got !== 14'h3000) begin
                errors++; $display("FAIL reset_mid_hold got=%h exp=%h", got, 14'h3000);
            end
        end
        reset = 1'b1;
        for (int k = 0; k < 50; k++) begin
            tick();
            checks++;
            if (got !== exp_vec() || expired[0] !== 1'b1 || expired_pulse[0] !== 1'b0) begin
                errors++; $display("FAIL reset_mid_after k=%0d got=%h exp=%h", k, got, exp_vec());
            end
        end
    endtask

    task automatic test_back_to_back();
        logic prev;
        int last_toggle, last_hz, toggles;
        last_toggle = -1; last_hz = -1; toggles = 0;
        value = {4'd3, 4'd2}; start = 2'b11;
        tick();
        start = 2'b00;
        prev = blink;
        for (int k = 1; k <= 45; k++) begin
            tick();
            checks++;
            if (got !== exp_vec()) begin
                errors++; $display("FAIL b2b_model k=%0d got=%h exp=%h", k, got, exp_vec());
            end
            if (blink !== prev && k <= 30) begin
                if (last_toggle >= 0) begin
                    checks++;
                    if (k - last_toggle != 5) begin
                        errors++; $display("FAIL blink_spacing got=%0d exp=5", k - last_toggle);
                    end
                end
                last_toggle = k;
                toggles++;
            end
            prev = blink;
            if (one_hz_enable) begin
                if (last_hz >= 0) begin
                    checks++;
                    if (k - last_hz != 10) begin
                        errors++; $display("FAIL one_hz_spacing got=%0d exp=10", k - last_hz);
                    end
                end
                last_hz = k;
            end
        end
        checks++;
        if (toggles < 4 || blink !== 1'b0) begin
            errors++; $display("FAIL blink_activity toggles=%0d exp>=4 final=%b exp=0", toggles, blink);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 800; k++) begin
            for (int i = 0; i < 2; i++) begin
                start[i] = ($urandom_range(0, 29) == 0);
                if ($urandom_range(0, 14) == 0) pause[i] = ~pause[i];
                value[i*4 +: 4] = 4'($urandom_range(0, 6));
            end
            tick();
            checks++;
            if (got !== exp_vec()) begin
                errors++; $display("FAIL random_model k=%0d got=%h exp=%h", k, got, exp_vec());
            end
        end
        start = '0;
        pause = '0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_countdown();
        test_pause();
        test_zero_start();
        test_restart();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multi_timer.md
MULTI_TIMER -- requirements
Module: multi_timer

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 100_000_000, giving clock cycles per second (even, >=4).
REQ-002 The block SHALL have parameter N_CH, default 2, giving the number of independent countdown channels (1..8).
REQ-003 The block SHALL have parameter VALUE_W, default 4, giving the width of each channel's seconds value.
REQ-004 clock  in  1  single system clock; all logic on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  N_CH  per-channel load/start strobe, sampled each clock.
REQ-007 pause  in  N_CH  per-channel level; 1 freezes that channel's countdown.
REQ-008 value  in  N_CH*VALUE_W  per-channel start value in seconds; channel i occupies bits [i*VALUE_W +: VALUE_W].
REQ-009 expired  out  N_CH  per-channel level, 1 when the channel is not counting.
REQ-010 expired_pulse  out  N_CH  per-channel one-cycle strobe on count reaching 0.
REQ-011 one_hz_enable  out  1  one-cycle strobe every CLK_HZ cycles, free-running.
REQ-012 blink  out  1  0.5 s high / 0.5 s low square wave for siren/LED use.
REQ-013 value_display  out  N_CH*VALUE_W  per-channel remaining seconds, same packing as value.

Function
REQ-014 Each channel SHALL hold state IDLE, RUN or PAUSED, a VALUE_W-bit count and a private prescaler 0..CLK_HZ-1.
REQ-015 Any state, start[i]=1 and value>0: next state RUN, count=value, prescaler=0; start has priority over pause and over a same-cycle expiry.
REQ-016 Any state, start[i]=1 and value=0: next state IDLE, count=0, expired_pulse[i]=1 for the following cycle.
REQ-017 RUN, pause[i]=1: next state PAUSED; count and prescaler frozen.
REQ-018 PAUSED, pause[i]=0: next state RUN; prescaler resumes from its frozen value.
REQ-019 RUN, prescaler<CLK_HZ-1: prescaler increments.
REQ-020 RUN, prescaler=CLK_HZ-1: prescaler=0, count decrements; if count was 1 next state IDLE and expired_pulse[i]=1 for exactly one cycle.
REQ-021 Expiry SHALL occur exactly value*CLK_HZ clock cycles after the cycle start was sampled, excluding paused cycles.
REQ-022 IDLE holds count=0, prescaler=0; no wrap-around below 0.
REQ-023 expired[i] SHALL equal (state==IDLE); value_display SHALL equal count; both registered, valid one cycle after start.
REQ-024 A global free-running prescaler SHALL assert one_hz_enable when it equals CLK_HZ-1, independent of channels.
REQ-025 blink SHALL toggle when the global prescaler equals CLK_HZ/2-1 or CLK_HZ-1 while any channel is RUN, and SHALL be forced 0 when no channel is RUN.
REQ-026 Channels SHALL be fully independent; simultaneous events on different channels in one cycle are all honoured.

Reset
REQ-027 reset=0 SHALL asynchronously force all channels IDLE, count=0, all prescalers=0, expired=all 1, expired_pulse=0, one_hz_enable=0, blink=0, value_display=0.
REQ-028 Reset asserted mid-count SHALL abort the countdown with no expired_pulse; after release a channel stays IDLE until start.

Structure
REQ-029 A shared package multi_timer_pkg SHALL hold the channel state encoding and the prescaler-width function (ceil log2 of CLK_HZ).
REQ-030 Per-channel logic (FSM, count, prescaler, pulse) SHALL be a sub-module timer_channel instantiated N_CH times by a generate loop; global prescaler and blink live in multi_timer.

Verification (bench uses CLK_HZ=10, N_CH=2, VALUE_W=4)
REQ-031 start[0]=1 with value0=3 -> value_display0 3,2,1,0 at cycles +10,+20,+30 after start; expired_pulse[0] single cycle at +30; expired[0]=1 thereafter.
REQ-032 start[0] value0=5, pause[0] high for 7 cycles after 12 cycles -> expiry at +57, not +50.
REQ-033 start[1] value1=0 -> expired[1] stays 1, expired_pulse[1]=1 one cycle later.
REQ-034 Re-start channel 0 with value0=9 in the cycle its count would reach 0 -> no expired_pulse, value_display0=9, new expiry 90 cycles later.
REQ-035 reset low at cycle 15 of a value=4 countdown -> all outputs at reset values immediately, no pulse; blink 0.
REQ-036 Both channels running -> blink toggles every 5 cycles, one_hz_enable every 10 cycles; blink returns to 0 once both expire.
